// File: rtl/conv_feeder_window_sched.sv
// conv_feeder_window_sched: round-robin window scheduler streaming padded pixel blocks into the conv feeder.
// Optional stall counter output when CONV_FEEDER_WINDOW_SCHED_PERF_EN is defined.
module conv_feeder_window_sched #(
   parameter int data_width = 32,
   parameter int coord_w = 10,
   parameter int max_outstanding = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [3:0]              win_dim,
   input  logic [1:0]              req_val,
   output logic [1:0]              req_rdy,
   input  logic [2*coord_w-1:0]    req_msg0,
   input  logic [2*coord_w-1:0]    req_msg1,
   output logic                    memreq_val,
   input  logic                    memreq_rdy,
   output logic [2*coord_w-1:0]    memreq_addr,
   input  logic                    memresp_val,
   output logic                    memresp_rdy,
   input  logic [data_width-1:0]   memresp_msg,
   output logic                    feed_val,
   output logic [data_width-1:0]   feed_msg,
   input  logic                    feed_rdy,
   input  logic                    calc_done,
   output logic                    win_owner,
   output logic                    busy
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
   ,output logic [31:0]            stall_cycles
`endif
);
   localparam int cw = $clog2(max_outstanding) + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_DONE} state_t;
   state_t state, state_nxt;
   logic rr_ptr, winner, grant, mem_fire, resp_fire, last_req;
   logic [coord_w-1:0] x0, y0;
   logic [4:0] side, r, c;
   logic [cw-1:0] credits;
   logic [8:0] beats;
   logic [9:0] area;
   assign memresp_rdy = feed_rdy;
   assign feed_val = memresp_val;
   assign feed_msg = memresp_msg;
   // grant is held off while reset is asserted so req_rdy reads 0 during reset
   assign grant = state == IDLE && (|req_val) && reset_n;
   assign winner = &req_val ? rr_ptr : req_val[1];
   assign mem_fire = memreq_val && memreq_rdy;
   assign resp_fire = memresp_val && feed_rdy;
   assign last_req = r == side - 5'd1 && c == side - 5'd1;
   assign area = 10'(side) * 10'(side);
   assign memreq_addr = {y0 + coord_w'(r), x0 + coord_w'(c)};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = grant ? ISSUE : IDLE;
         ISSUE:     state_nxt = mem_fire && last_req ? DRAIN : ISSUE;
         DRAIN:     state_nxt = {1'b0, beats} == area && credits == '0 ? WAIT_DONE : DRAIN;
         WAIT_DONE: state_nxt = calc_done ? IDLE : WAIT_DONE;
         default:   state_nxt = IDLE;
      endcase
   end
   always_comb begin
      req_rdy = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
      memreq_val = state == ISSUE && credits < cw'(max_outstanding);
      busy = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= 1'b0;
         win_owner <= 1'b0;
         x0 <= '0;
         y0 <= '0;
         side <= '0;
         r <= '0;
         c <= '0;
         beats <= '0;
         credits <= '0;
      end else begin
         if (grant) begin
            rr_ptr <= ~winner;
            win_owner <= winner;
            {y0, x0} <= winner ? req_msg1 : req_msg0;
            side <= {1'b0, win_dim} + 5'd2;
            r <= '0;
            c <= '0;
            beats <= '0;
         end else begin
            if (mem_fire) begin
               c <= c == side - 5'd1 ? 5'd0 : c + 5'd1;
               r <= c == side - 5'd1 ? r + 5'd1 : r;
            end
            if (resp_fire && state != IDLE) beats <= beats + 9'd1;
         end
         // responses still in flight from before a reset must not underflow the credit pool
         credits <= credits + cw'(mem_fire) - cw'(resp_fire && credits != '0);
      end
   end
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
   logic [32:0] stall_sum;
   assign stall_sum = {1'b0, stall_cycles} + 33'(memresp_val && !feed_rdy) + 33'(memreq_val && !memreq_rdy);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stall_cycles <= '0;
      else stall_cycles <= stall_sum[32] ? '1 : stall_sum[31:0];
   end
`endif
endmodule

// File: tb/tb_conv_feeder_window_sched.sv
// tb_conv_feeder_window_sched: scoreboard bench with a queue-based window model and randomized memory/feeder timing.
module tb_conv_feeder_window_sched;
   logic clk = 1'b0;
   logic reset_n;
   logic [3:0] win_dim;
   logic [1:0] req_val, req_rdy;
   logic [19:0] req_msg0, req_msg1, memreq_addr;
   logic memreq_val, memreq_rdy, memresp_val, memresp_rdy, feed_val, feed_rdy, calc_done, win_owner, busy;
   logic [31:0] memresp_msg, feed_msg;
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
   logic [31:0] stall_cycles;
   longint perf_exp = 0;
`endif
   logic [1:0] exp_gnt[$];
   logic [19:0] exp_addr[$];
   logic [19:0] pend[$];
   int win_end[$];
   int n_chk = 0, n_fail = 0;
   int req_fires = 0, resp_fires = 0, grants = 0, exp_grants = 0, exp_total = 0;
   int feed_mode = 1, rdy_mode = 1;
   bit resp_hold = 0, prio = 0, cur_owner = 0, own_chk = 0;
   logic [1:0] mon_g;
   logic [19:0] mon_a;

   conv_feeder_window_sched dut (
      .clk(clk), .reset_n(reset_n), .win_dim(win_dim), .req_val(req_val), .req_rdy(req_rdy),
      .req_msg0(req_msg0), .req_msg1(req_msg1), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memreq_addr(memreq_addr), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
      .memresp_msg(memresp_msg), .feed_val(feed_val), .feed_msg(feed_msg), .feed_rdy(feed_rdy),
      .calc_done(calc_done), .win_owner(win_owner), .busy(busy)
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // reference model: who wins, and the full row-major padded address list of that window
   task automatic expect_grant(input logic [1:0] rv, input logic [19:0] m0, input logic [19:0] m1, input logic [3:0] wd);
      bit w;
      logic [19:0] o;
      logic [9:0] ya, xa;
      int s;
      w = (rv == 2'b11) ? prio : rv[1];
      prio = !w;
      exp_gnt.push_back(w ? 2'b10 : 2'b01);
      exp_grants++;
      o = w ? m1 : m0;
      s = int'(wd) + 2;
      for (int rr = 0; rr < s; rr++)
         for (int cc = 0; cc < s; cc++) begin
            ya = 10'((int'(o[19:10]) + rr) % 1024);
            xa = 10'((int'(o[9:0]) + cc) % 1024);
            exp_addr.push_back({ya, xa});
         end
      exp_total += s * s;
      win_end.push_back(exp_total);
   endtask

   task automatic wait_grant();
      int t = 0;
      while (grants < exp_grants && t < 50) begin
         @(posedge clk);
         t++;
      end
      chk("grant_timeout", t < 50, 1);
      #1 req_val = 2'b00;
   endtask

   task automatic finish_window(input bit drop);
      int t = 0;
      int tgt;
      tgt = win_end.pop_front();
      while ((req_fires < tgt || resp_fires < tgt) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("window_timeout", t < 3000, 1);
      repeat (3) @(posedge clk);
      #3;
      chk("wait_done_busy", busy, 1);
      chk("wait_done_noreq", memreq_val, 0);
      @(posedge clk);
      #1;
      if (drop) req_val = 2'b00;
      calc_done = 1'b1;
      @(posedge clk);
      #1 calc_done = 1'b0;
      #2 chk("done_to_idle", busy, 0);
   endtask

   task automatic run_window(input logic [1:0] rv, input logic [19:0] m0, input logic [19:0] m1, input logic [3:0] wd);
      expect_grant(rv, m0, m1, wd);
      @(posedge clk);
      #1;
      req_msg0 = m0;
      req_msg1 = m1;
      win_dim = wd;
      req_val = rv;
      wait_grant();
      finish_window(1);
   endtask

   // memory and feeder side: responses only for requests the memory has accepted
   always begin
      @(posedge clk);
      #1;
      feed_rdy = feed_mode == 0 ? ($urandom_range(0, 3) != 0) : feed_mode == 1 ? 1'b1 : ~feed_rdy;
      memreq_rdy = rdy_mode == 0 ? ($urandom_range(0, 3) != 0) : rdy_mode == 1;
      memresp_val = !resp_hold && pend.size() > 0 && $urandom_range(0, 3) != 0;
      memresp_msg = $urandom;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("feed_mirror", {feed_val, feed_msg, memresp_rdy}, {memresp_val, memresp_msg, feed_rdy});
         if (req_rdy != 2'b00) begin
            if (exp_gnt.size() == 0) chk("unexpected_grant", req_rdy, 0);
            else begin
               mon_g = exp_gnt.pop_front();
               chk("grant", req_rdy, mon_g);
               cur_owner = mon_g[1];
               own_chk = 1;
            end
            grants++;
         end else if (own_chk && busy) begin
            chk("win_owner", win_owner, cur_owner);
            own_chk = 0;
         end
         if (memreq_val && !busy) chk("memreq_outside_issue", memreq_val, 0);
         if (memreq_val && memreq_rdy) begin
            chk("credit_limit", pend.size() < 4, 1);
            if (exp_addr.size() == 0) chk("unexpected_memreq", memreq_addr, 0);
            else chk("memreq_addr", memreq_addr, exp_addr.pop_front());
            pend.push_back(memreq_addr);
            req_fires++;
         end
         if (memresp_val && feed_rdy && pend.size() > 0) begin
            mon_a = pend.pop_front();
            resp_fires++;
         end
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
         if (calc_done) chk("stall_cycles", stall_cycles, perf_exp[31:0]);
         perf_exp += longint'(memresp_val && !feed_rdy) + longint'(memreq_val && !memreq_rdy);
`endif
      end
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
      else perf_exp = 0;
`endif
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no end, expected end of test");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [19:0] ma, mb;
      int base, t;
      reset_n = 0; req_val = 0; req_msg0 = 0; req_msg1 = 0; win_dim = 0; calc_done = 0;
      feed_rdy = 1; memresp_val = 0; memresp_msg = 0; memreq_rdy = 1;
      repeat (3) @(posedge clk);
      #3;
      chk("reset_req_rdy", req_rdy, 0);
      chk("reset_memreq_val", memreq_val, 0);
      chk("reset_busy", busy, 0);
      chk("reset_win_owner", win_owner, 0);
      @(posedge clk);
      #2 reset_n = 1;
      // single window, with memory refusing requests for the first 10 issue cycles
      rdy_mode = 2;
      @(posedge clk);
      #1;
      expect_grant(2'b01, {10'd5, 10'd7}, 20'd0, 4'd2);
      win_dim = 4'd2;
      req_msg0 = {10'd5, 10'd7};
      req_val = 2'b01;
      #2;
      chk("comb_grant", req_rdy, 2'b01);
      chk("grant_cycle_busy", busy, 0);
      @(posedge clk);
      #1 req_val = 2'b00;
      repeat (9) @(posedge clk);
      #2 rdy_mode = 1;
      @(posedge clk);
      #3;
`ifdef CONV_FEEDER_WINDOW_SCHED_PERF_EN
      chk("stall_10", stall_cycles, 10);
`endif
      chk("no_req_while_refused", req_fires, 0);
      finish_window(1);
      // coordinate wrap with toggling feeder ready
      feed_mode = 2;
      run_window(2'b10, 20'd0, {10'd1022, 10'd1023}, 4'd0);
      // round robin with both requesters held valid
      feed_mode = 0;
      rdy_mode = 0;
      ma = 20'($urandom);
      mb = 20'($urandom);
      for (int i = 0; i < 4; i++) expect_grant(2'b11, ma, mb, 4'd1);
      @(posedge clk);
      #1;
      req_msg0 = ma;
      req_msg1 = mb;
      win_dim = 4'd1;
      req_val = 2'b11;
      for (int i = 0; i < 4; i++) finish_window(i == 3);
      // credit limit with responses withheld; a stray calc_done must be ignored
      feed_mode = 1;
      rdy_mode = 1;
      resp_hold = 1;
      base = exp_total;
      ma = 20'($urandom);
      expect_grant(2'b01, ma, 20'd0, 4'd1);
      @(posedge clk);
      #1;
      req_msg0 = ma;
      win_dim = 4'd1;
      req_val = 2'b01;
      wait_grant();
      repeat (12) @(posedge clk);
      #3;
      chk("credit_cap", req_fires - base, 4);
      chk("credit_stall", memreq_val, 0);
      @(posedge clk);
      #1 calc_done = 1;
      @(posedge clk);
      #1 calc_done = 0;
      #2 chk("done_ignored", busy, 1);
      @(posedge clk);
      #1 resp_hold = 0;
      finish_window(1);
      // reset mid-window after 5 of 9 requests
      feed_mode = 0;
      base = exp_total;
      ma = 20'($urandom);
      expect_grant(2'b01, ma, 20'd0, 4'd1);
      @(posedge clk);
      #1;
      req_msg0 = ma;
      win_dim = 4'd1;
      req_val = 2'b01;
      wait_grant();
      t = 0;
      while (req_fires < base + 5 && t < 200) begin
         @(posedge clk);
         t++;
      end
      chk("abort_point", req_fires - base, 5);
      #2;
      reset_n = 0;
      memresp_val = 0;
      pend.delete();
      exp_addr.delete();
      exp_gnt.delete();
      win_end.delete();
      req_fires = 0; resp_fires = 0; grants = 0; exp_grants = 0; exp_total = 0;
      prio = 0; own_chk = 0;
      #1;
      chk("abort_req_rdy", req_rdy, 0);
      chk("abort_busy", busy, 0);
      chk("abort_memreq_val", memreq_val, 0);
      @(posedge clk);
      #2 reset_n = 1;
      run_window(2'b11, 20'($urandom), 20'($urandom), 4'd0);
      run_window(2'b10, 20'($urandom), 20'($urandom), 4'd1);
      // randomized windows, including the largest window
      for (int i = 0; i < 8; i++)
         run_window(2'($urandom_range(1, 3)), 20'($urandom), 20'($urandom), 4'($urandom_range(0, 5)));
      run_window(2'b11, 20'($urandom), 20'($urandom), 4'd15);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
